// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Round-robin arbiter sharing one data-memory port between the |
// |               CPU load/store path and the UART loader, with capped loader  |
// |               burst ownership and owner-tagged read return.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_lock,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
    localparam logic               c_OWN_CPU = 1'b0;
    localparam logic               c_OWN_LD  = 1'b1;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_last;
    logic [c_CNT_W-1:0]   r_burst_cnt;

    logic                 w_cpu_gnt;
    logic                 w_ld_gnt;
    logic                 w_burst_room;
    logic                 w_push_vld;
    logic                 w_push_own;
    logic                 w_ret_vld;
    logic                 w_ret_own;

    assign w_burst_room = (r_burst_cnt < c_MAX);

    // Grants are decided in the request cycle; reset forces every grant low.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ld_gnt  = 1'b0;
        if (rst) begin
            if (r_state == ST_BURST) begin
                if (ld_req && (w_burst_room || !cpu_req)) begin
                    w_ld_gnt = 1'b1;
                end else if (cpu_req) begin
                    w_cpu_gnt = 1'b1;
                end
            end else begin
                if (cpu_req && ld_req) begin
                    if (r_last == c_OWN_LD) begin
                        w_cpu_gnt = 1'b1;
                    end else begin
                        w_ld_gnt = 1'b1;
                    end
                end else begin
                    w_cpu_gnt = cpu_req;
                    w_ld_gnt  = ld_req;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_ARB;
            r_last      <= c_OWN_LD;
            r_burst_cnt <= '0;
        end else begin
            if (w_cpu_gnt) begin
                r_last <= c_OWN_CPU;
            end else if (w_ld_gnt) begin
                r_last <= c_OWN_LD;
            end

            case (r_state)
                ST_ARB: begin
                    if (w_ld_gnt && ld_lock) begin
                        r_state     <= ST_BURST;
                        r_burst_cnt <= c_ONE;
                    end
                end
                ST_BURST: begin
                    if (!ld_lock) begin
                        r_state     <= ST_ARB;
                        r_burst_cnt <= '0;
                    end else if (w_ld_gnt) begin
                        if (w_burst_room) begin
                            r_burst_cnt <= r_burst_cnt + c_ONE;
                        end
                    end else if (w_cpu_gnt && ld_req) begin
                        // CPU took its turn while the loader was waiting: budget renews.
                        r_burst_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_ARB;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign cpu_stall = rst & cpu_req & ~w_cpu_gnt;
    assign mem_en    = w_cpu_gnt | w_ld_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign w_push_vld = mem_en & ~mem_we;
    assign w_push_own = w_ld_gnt ? c_OWN_LD : c_OWN_CPU;

    // Owner tags travel alongside the memory latency so data lands on its issuer.
    generate
        if (RD_LAT == 1) begin : g_tag_single
            logic r_vld;
            logic r_own;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld <= 1'b0;
                    r_own <= c_OWN_CPU;
                end else begin
                    r_vld <= w_push_vld;
                    r_own <= w_push_own;
                end
            end

            assign w_ret_vld = r_vld;
            assign w_ret_own = r_own;
        end else begin : g_tag_multi
            logic [RD_LAT-1:0] r_vld;
            logic [RD_LAT-1:0] r_own;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld <= '0;
                    r_own <= '0;
                end else begin
                    r_vld <= {r_vld[RD_LAT-2:0], w_push_vld};
                    r_own <= {r_own[RD_LAT-2:0], w_push_own};
                end
            end

            assign w_ret_vld = r_vld[RD_LAT-1];
            assign w_ret_own = r_own[RD_LAT-1];
        end
    endgenerate

    assign cpu_rvalid = w_ret_vld & (w_ret_own == c_OWN_CPU);
    assign ld_rvalid  = w_ret_vld & (w_ret_own == c_OWN_LD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

endmodule
`default_nettype wire
